// File: rtl/validate_mcount_pkg.sv
// Shared defaults for the multi-channel confidence validator.
package validate_mcount_pkg;

    localparam int unsigned DEF_NCH          = 4;
    localparam int unsigned DEF_NBITS        = 16;
    localparam int unsigned DEF_CW           = 3;
    localparam int unsigned DEF_TOL          = 0;
    localparam int unsigned DEF_HOLD_ON_LOSS = 0;

endpackage

// File: rtl/validate_mcount_if.sv
// Sample-in / validated-status-out bundle between timing detectors and status registers.
interface validate_mcount_if
    import validate_mcount_pkg::*;
#(
    parameter int unsigned NCH   = DEF_NCH,
    parameter int unsigned NBITS = DEF_NBITS
);
    logic [NCH-1:0]       i_v;
    logic [NCH*NBITS-1:0] i_val;
    logic [NCH*NBITS-1:0] o_val;
    logic [NCH-1:0]       o_locked;
    logic [NCH-1:0]       o_event;

    modport master (
        output i_v, i_val,
        input  o_val, o_locked, o_event
    );

    modport slave (
        input  i_v, i_val,
        output o_val, o_locked, o_event
    );
endinterface

// File: rtl/validate_mcount_chan.sv
// One validator channel: sample stage, saturating confidence counter with
// forwarded reference compare, and registered value/lock/event outputs.
module validate_chan
    import validate_mcount_pkg::*;
#(
    parameter int unsigned NBITS        = DEF_NBITS,
    parameter int unsigned CW           = DEF_CW,
    parameter int unsigned TOL          = DEF_TOL,
    parameter int unsigned HOLD_ON_LOSS = DEF_HOLD_ON_LOSS
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_v,
    input  logic [NBITS-1:0] i_val,
    output logic [NBITS-1:0] o_val,
    output logic             o_locked,
    output logic             o_event
);
    localparam logic [CW-1:0] MAXCNT = {CW{1'b1}};
    localparam logic [NBITS:0] TOL_W = (NBITS+1)'(TOL);

    logic             r_v1;
    logic [NBITS-1:0] r_d1;
    logic             r_match1;
    logic             r_empty1;
    logic [NBITS-1:0] r_ref;
    logic [CW-1:0]    r_cnt;
    logic [NBITS-1:0] r_oval;
    logic             r_locked;
    logic             r_event;

    logic [NBITS-1:0] w_ref_next;
    logic [CW-1:0]    w_cnt_next;
    logic [NBITS:0]   w_diff;
    logic             w_match;
    logic             w_locked_next;

    // Counter/reference update for the sample held in stage 1
    always_comb begin
        w_ref_next = r_ref;
        w_cnt_next = r_cnt;
        if (r_v1) begin
            if (r_empty1) begin
                w_ref_next = r_d1;
                w_cnt_next = CW'(1);
            end else if (r_match1) begin
                if (r_cnt != MAXCNT) begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end else begin
                w_cnt_next = r_cnt - CW'(1);
            end
        end
    end

    // Compare against the reference being written this edge; one extra bit avoids wrap
    always_comb begin
        if (i_val >= w_ref_next) begin
            w_diff = {1'b0, i_val} - {1'b0, w_ref_next};
        end else begin
            w_diff = {1'b0, w_ref_next} - {1'b0, i_val};
        end
        w_match = (w_diff <= TOL_W);
    end

    always_comb begin
        w_locked_next = r_locked;
        if (r_cnt == MAXCNT) begin
            w_locked_next = 1'b1;
        end else if (r_cnt == '0) begin
            w_locked_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_v1     <= 1'b0;
            r_d1     <= '0;
            r_match1 <= 1'b0;
            r_empty1 <= 1'b1;
            r_ref    <= '0;
            r_cnt    <= '0;
            r_oval   <= '0;
            r_locked <= 1'b0;
            r_event  <= 1'b0;
        end else begin
            r_v1     <= i_v;
            r_d1     <= i_val;
            r_match1 <= w_match;
            r_empty1 <= (w_cnt_next == '0);
            r_ref    <= w_ref_next;
            r_cnt    <= w_cnt_next;
            r_locked <= w_locked_next;
            r_event  <= (w_locked_next != r_locked);
            if (r_cnt == MAXCNT) begin
                r_oval <= r_ref;
            end else if ((r_cnt == '0) && (HOLD_ON_LOSS == 0)) begin
                r_oval <= '0;
            end
        end
    end

    assign o_val    = r_oval;
    assign o_locked = r_locked;
    assign o_event  = r_event;

endmodule

// File: rtl/validate_mcount.sv
// Multi-channel measurement validator: independent channels plus bus packing.
module validate_mcount
    import validate_mcount_pkg::*;
#(
    parameter int unsigned NCH          = DEF_NCH,
    parameter int unsigned NBITS        = DEF_NBITS,
    parameter int unsigned CW           = DEF_CW,
    parameter int unsigned TOL          = DEF_TOL,
    parameter int unsigned HOLD_ON_LOSS = DEF_HOLD_ON_LOSS
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    validate_mcount_if.slave  bus
);
    function automatic int unsigned slice_lo(input int unsigned c);
        return c * NBITS;
    endfunction

    logic [NBITS-1:0] w_val [NCH];
    logic [NCH-1:0]   w_locked;
    logic [NCH-1:0]   w_event;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        validate_chan #(
            .NBITS        (NBITS),
            .CW           (CW),
            .TOL          (TOL),
            .HOLD_ON_LOSS (HOLD_ON_LOSS)
        ) u_chan (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_v       (bus.i_v[c]),
            .i_val     (bus.i_val[slice_lo(c) +: NBITS]),
            .o_val     (w_val[c]),
            .o_locked  (w_locked[c]),
            .o_event   (w_event[c])
        );
    end

    always_comb begin
        bus.o_val = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            bus.o_val[slice_lo(c) +: NBITS] = w_val[c];
        end
    end

    assign bus.o_locked = w_locked;
    assign bus.o_event  = w_event;

endmodule
